// File: rtl/booth4_pp_sequencer.sv
// booth4_pp_sequencer
// Sequential radix-4 Booth partial-product generator for a 16x16 signed
// multiplier. One operand pair is accepted over a valid/ready handshake.
// The eight 18-bit signed partial products (digit_i * X, weight 4^i) are
// then streamed out one per handshake. Zero digits are included.
//
// Optional feature: define BOOTH_ACC_EN to add an internal 32-bit
// accumulator. It drives product_o and product_valid_o.
module booth4_pp_sequencer (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [15:0] mcand_i,
  input  logic signed [15:0] mplier_i,
  output logic               pp_valid_o,
  input  logic               pp_ready_i,
  output logic signed [17:0] pp_o,
  output logic [2:0]         pp_idx_o,
  output logic               pp_last_o
`ifdef BOOTH_ACC_EN
  ,
  output logic signed [31:0] product_o,
  output logic               product_valid_o
`endif
);

  localparam int DATA_W = 16;
  localparam int PP_W   = 18;

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  x_r;
  logic        [DATA_W:0]    y_r;     // {Y, 1'b0}: bit 0 is the implicit Y[-1]
  logic        [2:0]         idx;
  logic        [2:0]         idx_nxt;
  logic                      pp_fire;

  // Choose the multiple of X selected by one Booth triplet {Y[2i+1],Y[2i],Y[2i-1]}.
  // The negation is done at 18 bits, so -(-32768) = +32768 is represented exactly.
  function automatic logic signed [PP_W-1:0] booth_multiple(
    input logic signed [DATA_W-1:0] x,
    input logic        [2:0]        trip
  );
    logic signed [PP_W-1:0] x_ext;
    logic signed [PP_W-1:0] x_neg;
    x_ext = {{(PP_W-DATA_W){x[DATA_W-1]}}, x};
    x_neg = ~x_ext + 18'sd1;
    case (trip)
      3'b001, 3'b010: booth_multiple = x_ext;
      3'b011:         booth_multiple = x_ext <<< 1;
      3'b100:         booth_multiple = x_neg <<< 1;
      3'b101, 3'b110: booth_multiple = x_neg;
      default:        booth_multiple = '0;
    endcase
  endfunction

  assign pp_fire  = pp_valid_o && pp_ready_i;
  assign idx_nxt  = idx + 3'd1;
  assign pp_idx_o = idx;

  // Control FSM. pp_o is registered from the next-state operands/index, so
  // pp_o has no combinational path from pp_ready_i.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      x_r        <= '0;
      y_r        <= '0;
      idx        <= '0;
      in_ready_o <= 1'b1;
      pp_valid_o <= 1'b0;
      pp_o       <= '0;
      pp_last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            state      <= GEN;
            x_r        <= mcand_i;
            y_r        <= {mplier_i, 1'b0};
            idx        <= '0;
            in_ready_o <= 1'b0;
            pp_valid_o <= 1'b1;
            pp_o       <= booth_multiple(mcand_i, {mplier_i[1:0], 1'b0});
            pp_last_o  <= 1'b0;
          end
        end
        GEN: begin
          if (pp_fire) begin
            if (idx == 3'd7) begin
              state      <= IDLE;
              idx        <= '0;
              in_ready_o <= 1'b1;
              pp_valid_o <= 1'b0;
              pp_o       <= '0;
              pp_last_o  <= 1'b0;
            end else begin
              idx        <= idx_nxt;
              pp_o       <= booth_multiple(x_r, y_r[{idx_nxt, 1'b0} +: 3]);
              pp_last_o  <= (idx_nxt == 3'd7);
            end
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_o <= 1'b1;
          pp_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef BOOTH_ACC_EN
  logic signed [31:0] acc;
  logic signed [31:0] pp_ext;
  logic signed [31:0] acc_sum;

  assign pp_ext  = {{(32-PP_W){pp_o[PP_W-1]}}, pp_o};
  assign acc_sum = acc + (pp_ext <<< {idx, 1'b0});

  // Accumulate the weighted partial products. The final sum lands in product_o with a one-cycle valid.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc             <= '0;
      product_o       <= '0;
      product_valid_o <= 1'b0;
    end else begin
      product_valid_o <= 1'b0;
      if (state == IDLE && in_valid_i && in_ready_o) begin
        acc       <= '0;
        product_o <= '0;
      end else if (state == GEN && pp_fire) begin
        acc <= acc_sum;
        if (idx == 3'd7) begin
          product_o       <= acc_sum;
          product_valid_o <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
